// File: rtl/multu_sequencer.sv
// Control sequencer for the 32-iteration shift-add MULTU unit: load/step/write strobes,
// HI/LO write timing and EX-stage stalls for instructions that depend on the busy unit.
module multu_sequencer #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic             flush,
  output logic             mul_load,
  output logic             mul_step,
  output logic             hilo_we,
  output logic             busy,
  output logic             stall,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [5:0]       alu_sel
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] SEL_HL  = 6'b111111;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_live, w_dep, w_hz, w_trig;

  // A flushed instruction neither starts a multiply nor waits on one.
  assign w_live = valid & ~flush;
  assign w_dep  = (funct == F_MFHI) | (funct == F_MFLO) | (funct == F_MULTU);
  assign w_hz   = w_live & busy & w_dep;
  assign w_trig = w_live & ~stall & (funct == F_MULTU);

  assign busy      = (r_state != S_IDLE);
  assign mul_step  = (r_state == S_RUN);
  assign hilo_we   = (r_state == S_WRITE);
  assign stall     = w_hz;
  assign mul_load  = w_trig & (r_state == S_IDLE) & ~reset;
  assign cycle_cnt = r_cnt;
  assign alu_sel   = hilo_we ? SEL_HL : funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (r_cnt == LAST) begin
            r_state <= S_WRITE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench: the driver pushes a per-cycle expected output vector into a queue,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_multu_sequencer;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_NOP   = 6'b000000;

  typedef struct packed {
    logic       ld, st, we, bz, sl;
    logic [5:0] cnt;
    logic [5:0] sel;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  e;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] funct = '0;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic       mul_load, mul_step, hilo_we, busy, stall;
  logic [5:0] cycle_cnt, alu_sel;

  int checks = 0;
  int errors = 0;
  sb_t sb[$];

  multu_sequencer dut (
    .clk(clk), .reset(reset), .funct(funct), .valid(valid), .flush(flush),
    .mul_load(mul_load), .mul_step(mul_step), .hilo_we(hilo_we), .busy(busy),
    .stall(stall), .cycle_cnt(cycle_cnt), .alu_sel(alu_sel)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic ld, st, we, bz, sl, logic [5:0] cnt, sel);
    exp_t e;
    e.ld = ld; e.st = st; e.we = we; e.bz = bz; e.sl = sl; e.cnt = cnt; e.sel = sel;
    return e;
  endfunction

  // Expected outputs k cycles after a MULTU was accepted (k=0 is the accept cycle),
  // following the documented timeline: steps 1..32, write 33, idle from 34.
  function automatic exp_t after_mul(int k, logic [5:0] f, logic v, logic fl);
    logic st, we, bz, dep;
    st  = (k >= 1) && (k <= 32);
    we  = (k == 33);
    bz  = (k >= 1) && (k <= 33);
    dep = (f == F_MFHI) || (f == F_MFLO) || (f == F_MULTU);
    return mk(k == 0, st, we, bz, v & ~fl & bz & dep,
              st ? 6'(k - 1) : 6'd0, we ? 6'b111111 : f);
  endfunction

  task automatic drive(string tag, logic [5:0] f, logic v, logic fl, logic rs, exp_t e);
    sb_t item;
    @(posedge clk);
    #1;
    funct = f; valid = v; flush = fl; reset = rs;
    item.tag = tag; item.e = e;
    sb.push_back(item);
  endtask

  // Monitor: compares once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t  item;
      exp_t act;
      item = sb.pop_front();
      act = mk(mul_load, mul_step, hilo_we, busy, stall, cycle_cnt, alu_sel);
      checks++;
      if (act !== item.e) begin
        errors++;
        $display("FAIL %s t=%0t act ld=%b st=%b we=%b bz=%b sl=%b cnt=%0d sel=%b exp ld=%b st=%b we=%b bz=%b sl=%b cnt=%0d sel=%b",
                 item.tag, $time, act.ld, act.st, act.we, act.bz, act.sl, act.cnt, act.sel,
                 item.e.ld, item.e.st, item.e.we, item.e.bz, item.e.sl, item.e.cnt, item.e.sel);
      end
    end
  end

  initial begin
    // Reset state: MULTU presented while reset is held must not load.
    drive("reset_hold", F_MULTU, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 6'd0, F_MULTU));
    drive("reset_idle", F_NOP, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_NOP));

    // 1: basic MULTU latency
    drive("t1_load", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(0, F_MULTU, 1'b1, 1'b0));
    for (int k = 1; k <= 34; k++)
      drive("t1_seq", F_NOP, 1'b0, 1'b0, 1'b0, after_mul(k, F_NOP, 1'b0, 1'b0));

    // 2: MFHI waits for the write, then proceeds
    drive("t2_load", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(0, F_MULTU, 1'b1, 1'b0));
    for (int k = 1; k <= 4; k++)
      drive("t2_pre", F_NOP, 1'b0, 1'b0, 1'b0, after_mul(k, F_NOP, 1'b0, 1'b0));
    for (int k = 5; k <= 33; k++)
      drive("t2_stall", F_MFHI, 1'b1, 1'b0, 1'b0, after_mul(k, F_MFHI, 1'b1, 1'b0));
    drive("t2_release", F_MFHI, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_MFHI));

    // 3: back-to-back MULTU; second accepted at c34, writes at c67
    drive("t3_load1", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(0, F_MULTU, 1'b1, 1'b0));
    for (int k = 1; k <= 33; k++)
      drive("t3_stall", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(k, F_MULTU, 1'b1, 1'b0));
    drive("t3_load2", F_MULTU, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 6'd0, F_MULTU));
    for (int k = 35; k <= 68; k++)
      drive("t3_seq2", F_NOP, 1'b0, 1'b0, 1'b0, after_mul(k - 34, F_NOP, 1'b0, 1'b0));

    // 4: reset mid-RUN aborts without any HI/LO write
    drive("t4_load", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(0, F_MULTU, 1'b1, 1'b0));
    for (int k = 1; k <= 19; k++)
      drive("t4_run", F_NOP, 1'b0, 1'b0, 1'b0, after_mul(k, F_NOP, 1'b0, 1'b0));
    drive("t4_reset", F_NOP, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 6'd0, F_NOP));
    for (int k = 21; k <= 40; k++)
      drive("t4_after", F_NOP, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_NOP));

    // 5: MULTU as bubble or flushed is ignored
    drive("t5_novalid", F_MULTU, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_MULTU));
    drive("t5_novalid_n", F_NOP, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_NOP));
    drive("t5_flush", F_MULTU, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_MULTU));
    drive("t5_flush_n", F_NOP, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 6'd0, F_NOP));

    // 6: independent ADD flows during RUN; flushed MFLO does not stall; flush ignored by run
    drive("t6_load", F_MULTU, 1'b1, 1'b0, 1'b0, after_mul(0, F_MULTU, 1'b1, 1'b0));
    for (int k = 1; k <= 10; k++)
      drive("t6_add", F_ADD, 1'b1, 1'b0, 1'b0, after_mul(k, F_ADD, 1'b1, 1'b0));
    drive("t6_flush_mflo", F_MFLO, 1'b1, 1'b1, 1'b0, after_mul(11, F_MFLO, 1'b1, 1'b1));
    drive("t6_mflo", F_MFLO, 1'b1, 1'b0, 1'b0, after_mul(12, F_MFLO, 1'b1, 1'b0));
    for (int k = 13; k <= 34; k++)
      drive("t6_tail", F_NOP, 1'b0, 1'b0, 1'b0, after_mul(k, F_NOP, 1'b0, 1'b0));

    // Bounded drain of the scoreboard.
    begin
      int budget = 20;
      while (sb.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain remaining=%0d required=0", sb.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
